// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, FSM states and BCD helper for operand capture
package calc_pkg;

    localparam logic [3:0] KEY_NEXT  = 4'hA;
    localparam logic [3:0] KEY_EQ    = 4'hB;
    localparam logic [3:0] KEY_CLR   = 4'hC;
    localparam logic [3:0] BLANK_NIB = 4'hF;
    localparam logic [7:0] BLANK_OP  = {BLANK_NIB, BLANK_NIB};

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        START,
        WAIT,
        DONE
    } estado_t;

    typedef enum logic [1:0] {
        FASE_A    = 2'd0,
        FASE_B    = 2'd1,
        FASE_WAIT = 2'd2,
        FASE_DONE = 2'd3
    } fase_t;

    // Same nibble-to-value mapping the divider applies to its operands.
    function automatic logic [3:0] bcd_val(input logic [7:0] op);
        logic [3:0] tens_v;
        logic [3:0] units_v;
        tens_v  = (op[7:4] == 4'd1) ? 4'd10 : 4'd0;
        units_v = (op[3:0] == BLANK_NIB) ? 4'd0 : op[3:0];
        return tens_v + units_v;
    endfunction

endpackage

// File: rtl/acum_operando.sv
// rtl/acum_operando.sv - two-digit BCD operand accumulator limited to 0..15
module acum_operando
    import calc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load_digit,
    input  logic [3:0] digit,
    output logic [7:0] bcd,
    output logic       empty,
    output logic       accepted,
    output logic       reject
);

    logic [7:0] bcd_q;
    logic [3:0] tens;
    logic [3:0] units;
    logic       base_empty;
    logic       fits;
    logic [7:0] bcd_cand;

    assign tens  = bcd_q[7:4];
    assign units = bcd_q[3:0];

    // A clear arriving with a digit restarts the operand from that digit.
    always_comb begin
        base_empty = clr || (bcd_q == BLANK_OP);
        fits       = 1'b0;
        bcd_cand   = bcd_q;
        if (base_empty) begin
            fits     = 1'b1;
            bcd_cand = {BLANK_NIB, digit};
        end else if (tens == BLANK_NIB &&
                     (units == 4'd0 || (units == 4'd1 && digit <= 4'd5))) begin
            fits     = 1'b1;
            bcd_cand = {units, digit};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_q <= BLANK_OP;
        end else if (load_digit && fits) begin
            bcd_q <= bcd_cand;
        end else if (clr) begin
            bcd_q <= BLANK_OP;
        end
    end

    assign bcd      = bcd_q;
    assign empty    = (bcd_q == BLANK_OP);
    assign accepted = load_digit && fits;
    assign reject   = load_digit && !fits;

endmodule

// File: rtl/captura_operandos.sv
// rtl/captura_operandos.sv - keypad operand capture and divider sequencing
module captura_operandos
    import calc_pkg::*;
#(
    parameter int DIV_LATENCY = 4,
    parameter int CNT_W       = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [7:0] a_bcd,
    output logic [7:0] b_bcd,
    output logic       start,
    output logic       busy,
    output logic       result_valid,
    output logic       err,
    output logic [1:0] fase
);

    estado_t          state;
    estado_t          state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             err_q;
    logic             err_next;

    logic key_digit;
    logic key_next;
    logic key_eq;
    logic key_clr;

    logic a_load;
    logic b_load;
    logic op_clr;
    logic a_empty;
    logic b_empty;
    logic a_accepted;
    logic b_accepted_unused;
    logic a_reject;
    logic b_reject;

    assign key_digit = key_valid && (key_code <= 4'd9);
    assign key_next  = key_valid && (key_code == KEY_NEXT);
    assign key_eq    = key_valid && (key_code == KEY_EQ);
    assign key_clr   = key_valid && (key_code == KEY_CLR);

    // A digit in DONE starts a fresh calculation: both operands cleared, digit lands in A.
    assign a_load = key_digit && (state == ENTER_A || state == DONE);
    assign b_load = key_digit && (state == ENTER_B);
    assign op_clr = key_clr || (key_digit && state == DONE);

    acum_operando u_op_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (op_clr),
        .load_digit (a_load),
        .digit      (key_code),
        .bcd        (a_bcd),
        .empty      (a_empty),
        .accepted   (a_accepted),
        .reject     (a_reject)
    );

    acum_operando u_op_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (op_clr),
        .load_digit (b_load),
        .digit      (key_code),
        .bcd        (b_bcd),
        .empty      (b_empty),
        .accepted   (b_accepted_unused),
        .reject     (b_reject)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ENTER_A;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            err_q <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        err_next   = 1'b0;
        if (key_clr) begin
            state_next = ENTER_A;
            cnt_next   = '0;
        end else begin
            case (state)
                ENTER_A: begin
                    if (a_reject || key_eq) begin
                        err_next = 1'b1;
                    end else if (key_next) begin
                        if (a_empty) err_next = 1'b1;
                        else         state_next = ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (b_reject || key_next) begin
                        err_next = 1'b1;
                    end else if (key_eq) begin
                        if (b_empty || bcd_val(b_bcd) == 4'd0) err_next = 1'b1;
                        else                                   state_next = START;
                    end
                end
                START: begin
                    state_next = WAIT;
                    cnt_next   = CNT_W'(DIV_LATENCY);
                end
                // Last count expires on this edge, so DONE follows DIV_LATENCY WAIT cycles.
                WAIT: begin
                    if (cnt <= CNT_W'(1)) begin
                        cnt_next   = '0;
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (a_accepted) state_next = ENTER_A;
                end
                default: begin
                    state_next = ENTER_A;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        fase = FASE_A;
        case (state)
            ENTER_A: fase = FASE_A;
            ENTER_B: fase = FASE_B;
            START,
            WAIT:    fase = FASE_WAIT;
            DONE:    fase = FASE_DONE;
            default: fase = FASE_A;
        endcase
    end

    assign start        = (state == START);
    assign busy         = (state == START) || (state == WAIT);
    assign result_valid = (state == DONE);
    assign err          = err_q;

endmodule

// File: doc/captura_operandos.md
Name: captura_operandos

Overview:
- Upstream stage of the BCD restoring divider (the `operacion` block) on the board.
- Consumes debounced keypad events and assembles the two-digit BCD dividend and divisor, range 0..15.
- Issues the divider's 1-cycle `start` pulse, then times the fixed divider latency and flags when quotient/remainder are final.
- Rejects out-of-range entries and division by zero before they reach the divider.

Parameters:
- DIV_LATENCY, 4: clock edges after the `start` cycle until the divider outputs are final (one per quotient bit).
- CNT_W, 3: width of the latency counter; must satisfy 2**CNT_W > DIV_LATENCY.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- key_valid  in  1  1-cycle pulse; key_code is valid this cycle.
- key_code  in  4  0x0-0x9 digit, 0xA NEXT (÷), 0xB EQUALS, 0xC CLEAR, 0xD-0xF ignored.
- a_bcd  out  8  dividend {tens, units}; 0xF nibble = blank.
- b_bcd  out  8  divisor {tens, units}; 0xF nibble = blank.
- start  out  1  1-cycle pulse to the divider.
- busy  out  1  high while the division is in flight.
- result_valid  out  1  divider quotient/remainder are final.
- err  out  1  1-cycle pulse when a key is rejected.
- fase  out  2  0 = ENTER_A, 1 = ENTER_B, 2 = WAIT (incl. START), 3 = DONE; drives the display mux.

Behaviour:
- Clock, reset and sampling:
  - Clock is clk; reset is rst_n, synchronous, active-low.
  - All state updates occur on the rising edge of clk.
  - Reset values: a_bcd = b_bcd = 8'hFF, start = busy = result_valid = err = 0, state ENTER_A, counter 0.
  - rst_n low mid-division returns to reset values on the next edge.
- Digit accumulation (per operand, states ENTER_A / ENTER_B):
  - Empty {F,F} + digit d gives {F,d}.
  - {F,f} + digit e is accepted only when f == 0, or when f == 1 and e <= 5; result {f,e}.
  - {F,f} with f >= 2 + any digit: rejected.
  - Full operand {t,u} + any digit: rejected.
  - Any rejected digit leaves the operand unchanged and pulses err.
- ENTER_A:
  - Digit: accumulate into A.
  - NEXT: go to ENTER_B if A is non-empty, else err.
  - EQUALS: err.
- ENTER_B:
  - Digit: accumulate into B.
  - EQUALS: if B is non-empty and its value != 0, go to START; else err (divide by zero or empty divisor).
  - NEXT: err.
- START:
  - Exactly one cycle with start = 1 and busy = 1.
  - Counter loads DIV_LATENCY; go to WAIT.
  - a_bcd and b_bcd are held stable from START through DONE.
- WAIT:
  - busy = 1; counter decrements each cycle.
  - When the counter reaches 0: result_valid = 1 on the next edge, busy = 0, go to DONE.
  - Digit, NEXT and EQUALS keys are ignored silently (no err).
- DONE:
  - result_valid is held high.
  - Digit: clear both operands to 8'hFF, accumulate the digit into A, go to ENTER_A, result_valid = 0.
  - NEXT and EQUALS are ignored.
- CLEAR, in any state:
  - Next edge: operands 8'hFF, state ENTER_A, result_valid = 0, busy = 0, counter 0.
  - A CLEAR during WAIT aborts the wait; the divider is left to finish, and its output is ignored.
- Keys 0xD-0xF: ignored in every state, no err.
- key_valid low: no state change except the WAIT countdown.
- err never coincides with start.
- Value check: B value = (tens == 1 ? 10 : 0) + (units == F ? 0 : units), the same mapping the divider uses.

Decomposition:
- Package `calc_pkg`:
  - key code constants KEY_NEXT = 4'hA, KEY_EQ = 4'hB, KEY_CLR = 4'hC.
  - BLANK_NIB = 4'hF.
  - enum estado_t {ENTER_A, ENTER_B, START, WAIT, DONE}.
  - function bcd_val(8-bit) returning a 4-bit value.
- Sub-module `acum_operando`, instantiated twice (A and B):
  - inputs: clk, rst_n, clr, load_digit, digit.
  - outputs: bcd[7:0], empty, accepted, reject.
  - holds the digit-accumulation rules.
- Top-level FSM, latency counter and fase encoding live in `captura_operandos`.

Test Plan:
- Keys 1,3,NEXT,4,EQUALS:
  - a_bcd = 8'h13 and b_bcd = 8'hF4.
  - start high exactly 1 cycle after the EQUALS edge; busy for 1+DIV_LATENCY cycles.
  - result_valid rises 5 edges after start; fase = 3.
- Keys 2,5: a_bcd = 8'hF2 and err pulses once. Keys 1,6: a_bcd = 8'hF1 with err. Keys 1,5,7: a_bcd = 8'h15 with err on the 7.
- Keys 9,NEXT,0,EQUALS → err, state stays ENTER_B, no start. Then CLEAR,0,NEXT,EQUALS → err at EQUALS (B empty).
- Start a division, then CLEAR two cycles after start → next edge busy = 0, fase = 0, operands 8'hFF, result_valid never asserts.
- From DONE, key 7 → a_bcd = 8'hF7, b_bcd = 8'hFF, result_valid = 0. Keys NEXT and 0xE in DONE → no change, no err.
- rst_n low for 1 cycle during WAIT, with key_valid high at the same edge → all outputs at reset values; the key has no effect.
